// File: rtl/rv_pkg.sv
// Shared widths and index/word types for the operand fetch slice.
package rv_pkg;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   typedef logic [AW-1:0]   reg_idx_t;
   typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// One busy bit per architectural register; set on issue, cleared on writeback or on
// flush of the entry that owns it. A set wins over a clear in the same cycle.
module reg_scoreboard
   import rv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            set_en_i,
   input  reg_idx_t        set_idx_i,
   input  logic            wb_en_i,
   input  reg_idx_t        wb_idx_i,
   input  logic            flush_en_i,
   input  reg_idx_t        flush_idx_i,
   output logic [NREG-1:0] busy_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (wb_en_i)    busy_d[wb_idx_i]    = 1'b0;
      if (flush_en_i) busy_d[flush_idx_i] = 1'b0;
      if (set_en_i)   busy_d[set_idx_i]   = 1'b1;
      // x0 is never a real destination, so it can never be owned.
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads rs1/rs2, bypasses same-cycle writeback, forces x0 to zero,
// stalls on RAW/WAW against the scoreboard, and registers the entry for EX.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid must not depend on ready, and a held entry stays stable until taken or flushed.
module operand_fetch_stage
   import rv_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     valid_i,
   output logic     ready_o,
   input  word_t    instr_i,
   input  reg_idx_t rs1_i,
   input  reg_idx_t rs2_i,
   input  reg_idx_t rd_i,
   input  logic     rd_wen_i,
   output reg_idx_t rf_rs1_o,
   output reg_idx_t rf_rs2_o,
   input  word_t    rf_data1_i,
   input  word_t    rf_data2_i,
   input  logic     wb_en_i,
   input  reg_idx_t wb_rd_i,
   input  word_t    wb_data_i,
   input  logic     flush_i,
   output logic     valid_o,
   input  logic     ready_i,
   output word_t    instr_o,
   output word_t    op1_o,
   output word_t    op2_o,
   output reg_idx_t rd_o,
   output logic     rd_wen_o
);

   logic [NREG-1:0] busy;
   logic            hit1, hit2, hitd;
   logic            stall1, stall2, stall_waw, hazard;
   logic            accept;
   word_t           op1_d, op2_d;

   logic     valid_q;
   word_t    instr_q, op1_q, op2_q;
   reg_idx_t rd_q;
   logic     rd_wen_q;

   assign rf_rs1_o = rs1_i;
   assign rf_rs2_o = rs2_i;

   assign hit1 = wb_en_i && (wb_rd_i == rs1_i) && (rs1_i != '0);
   assign hit2 = wb_en_i && (wb_rd_i == rs2_i) && (rs2_i != '0);
   assign hitd = wb_en_i && (wb_rd_i == rd_i)  && (rd_i  != '0);

   // The file returns the old value during its write cycle, so take wb_data_i directly.
   always_comb begin
      op1_d = rf_data1_i;
      op2_d = rf_data2_i;
      if (rs1_i == '0) op1_d = '0;
      else if (hit1)   op1_d = wb_data_i;
      if (rs2_i == '0) op2_d = '0;
      else if (hit2)   op2_d = wb_data_i;
   end

   assign stall1    = busy[rs1_i] && !hit1;
   assign stall2    = busy[rs2_i] && !hit2;
   assign stall_waw = rd_wen_i && busy[rd_i] && !hitd;
   assign hazard    = stall1 || stall2 || stall_waw;

   assign ready_o = !flush_i && (!valid_q || ready_i) && !hazard;
   assign accept  = valid_i && ready_o;

   reg_scoreboard u_sb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .set_en_i    (accept && rd_wen_i),
      .set_idx_i   (rd_i),
      .wb_en_i     (wb_en_i),
      .wb_idx_i    (wb_rd_i),
      .flush_en_i  (flush_i && valid_q && rd_wen_q),
      .flush_idx_i (rd_q),
      .busy_o      (busy)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         instr_q  <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         rd_q     <= '0;
         rd_wen_q <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q  <= 1'b1;
         instr_q  <= instr_i;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         rd_q     <= rd_i;
         rd_wen_q <= rd_wen_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o  = valid_q;
   assign instr_o  = instr_q;
   assign op1_o    = op1_q;
   assign op2_o    = op2_q;
   assign rd_o     = rd_q;
   assign rd_wen_o = rd_wen_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: bypass, x0, RAW/WAW stalls, backpressure, flush.
module tb_operand_fetch_stage;
   import rv_pkg::*;

   logic     clk = 1'b0;
   logic     rst_i, valid_i, ready_o, rd_wen_i, wb_en_i, flush_i, valid_o, ready_i, rd_wen_o;
   word_t    instr_i, rf_data1_i, rf_data2_i, wb_data_i, instr_o, op1_o, op2_o;
   reg_idx_t rs1_i, rs2_i, rd_i, rf_rs1_o, rf_rs2_o, wb_rd_i, rd_o;

   int total = 0;
   int bad   = 0;

   operand_fetch_stage dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .rd_wen_i(rd_wen_i),
      .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o), .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i),
      .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .op1_o(op1_o), .op2_o(op2_o),
      .rd_o(rd_o), .rd_wen_o(rd_wen_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1ns after it, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input word_t ins, input reg_idx_t s1, input reg_idx_t s2,
                          input reg_idx_t d, input logic wen, input word_t d1, input word_t d2);
      valid_i = 1'b1; instr_i = ins; rs1_i = s1; rs2_i = s2; rd_i = d; rd_wen_i = wen;
      rf_data1_i = d1; rf_data2_i = d2;
   endtask

   task automatic wb(input logic en, input reg_idx_t r, input word_t v);
      wb_en_i = en; wb_rd_i = r; wb_data_i = v;
   endtask

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; instr_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
      rd_wen_i = 1'b0; rf_data1_i = '0; rf_data2_i = '0; flush_i = 1'b0; ready_i = 1'b0;
      wb(1'b0, '0, '0);
      tick(); tick();
      rst_i = 1'b0;
      #1;
      chk("rst_valid", {31'b0, valid_o}, 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_op1", op1_o, 32'd0);
      chk("rst_op2", op2_o, 32'd0);
      chk("rst_rd", {27'b0, rd_o}, 32'd0);
      chk("rst_busy", dut.busy, 32'd0);
      chk("rst_ready", {31'b0, ready_o}, 32'd1);

      // 1. add x3,x1,x2 with x1=5, x2=7
      ready_i = 1'b1;
      present(32'h002081B3, 5'd1, 5'd2, 5'd3, 1'b1, 32'd5, 32'd7);
      #1;
      chk("t1_rf_rs1", {27'b0, rf_rs1_o}, 32'd1);
      chk("t1_rf_rs2", {27'b0, rf_rs2_o}, 32'd2);
      chk("t1_ready", {31'b0, ready_o}, 32'd1);
      tick();
      valid_i = 1'b0;
      chk("t1_valid", {31'b0, valid_o}, 32'd1);
      chk("t1_instr", instr_o, 32'h002081B3);
      chk("t1_op1", op1_o, 32'd5);
      chk("t1_op2", op2_o, 32'd7);
      chk("t1_rd", {27'b0, rd_o}, 32'd3);
      chk("t1_busy3", {31'b0, dut.busy[3]}, 32'd1);

      // 2. RAW on x3, resolved by same-cycle writeback bypass
      present(32'h00018233, 5'd3, 5'd0, 5'd5, 1'b0, 32'd0, 32'd7);
      #1;
      chk("t2_stall_a", {31'b0, ready_o}, 32'd0);
      tick();
      chk("t2_drained", {31'b0, valid_o}, 32'd0);
      chk("t2_stall_b", {31'b0, ready_o}, 32'd0);
      wb(1'b1, 5'd3, 32'h0000DEAD);
      #1;
      chk("t2_ready_on_wb", {31'b0, ready_o}, 32'd1);
      tick();
      valid_i = 1'b0; wb(1'b0, '0, '0);
      chk("t2_valid", {31'b0, valid_o}, 32'd1);
      chk("t2_op1_bypass", op1_o, 32'h0000DEAD);
      chk("t2_op2_x0", op2_o, 32'd0);
      chk("t2_busy3", {31'b0, dut.busy[3]}, 32'd0);

      // 3. x0 reads zero even with wb to x0; rd=0 never sets busy
      present(32'h00000013, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wb(1'b1, 5'd0, 32'h0000_1234);
      #1;
      chk("t3_ready", {31'b0, ready_o}, 32'd1);
      tick();
      valid_i = 1'b0; wb(1'b0, '0, '0);
      chk("t3_op1", op1_o, 32'd0);
      chk("t3_op2", op2_o, 32'd0);
      chk("t3_rd_wen", {31'b0, rd_wen_o}, 32'd1);
      chk("t3_busy_all", dut.busy, 32'd0);

      // 4. Backpressure: A held for 3 cycles while B waits
      present(32'h0000AAAA, 5'd1, 5'd2, 5'd7, 1'b1, 32'd11, 32'd22);
      tick();
      ready_i = 1'b0;
      present(32'h0000BBBB, 5'd1, 5'd2, 5'd8, 1'b1, 32'd33, 32'd44);
      for (int i = 0; i < 3; i++) begin
         chk("t4_ready_held", {31'b0, ready_o}, 32'd0);
         tick();
         chk("t4_valid_held", {31'b0, valid_o}, 32'd1);
         chk("t4_instr_held", instr_o, 32'h0000AAAA);
         chk("t4_op1_held", op1_o, 32'd11);
         chk("t4_op2_held", op2_o, 32'd22);
         chk("t4_rd_held", {27'b0, rd_o}, 32'd7);
      end
      ready_i = 1'b1;
      #1;
      chk("t4_ready_release", {31'b0, ready_o}, 32'd1);
      tick();
      chk("t4_instr_b", instr_o, 32'h0000BBBB);
      chk("t4_op1_b", op1_o, 32'd33);
      chk("t4_op2_b", op2_o, 32'd44);
      chk("t4_rd_b", {27'b0, rd_o}, 32'd8);
      chk("t4_busy78", {30'b0, dut.busy[8], dut.busy[7]}, 32'd3);

      // 5. rd=4 held, flushed, then rd=4 reissued; WAW on x7
      present(32'h0000CCCC, 5'd0, 5'd0, 5'd4, 1'b1, 32'd1, 32'd2);
      tick();
      valid_i = 1'b0; ready_i = 1'b0;
      chk("t5_busy4_set", {31'b0, dut.busy[4]}, 32'd1);
      chk("t5_rd_held", {27'b0, rd_o}, 32'd4);
      present(32'h0000DDDD, 5'd0, 5'd0, 5'd4, 1'b1, 32'd1, 32'd2);
      flush_i = 1'b1;
      #1;
      chk("t5_ready_flush", {31'b0, ready_o}, 32'd0);
      tick();
      flush_i = 1'b0;
      #1;
      chk("t5_valid_flushed", {31'b0, valid_o}, 32'd0);
      chk("t5_busy4_clr", {31'b0, dut.busy[4]}, 32'd0);
      chk("t5_busy7_kept", {31'b0, dut.busy[7]}, 32'd1);
      chk("t5_ready_after", {31'b0, ready_o}, 32'd1);
      tick();
      valid_i = 1'b0;
      chk("t5_valid_d", {31'b0, valid_o}, 32'd1);
      chk("t5_instr_d", instr_o, 32'h0000DDDD);
      chk("t5_busy4_again", {31'b0, dut.busy[4]}, 32'd1);
      ready_i = 1'b1;
      present(32'h0000EEEE, 5'd0, 5'd0, 5'd7, 1'b1, 32'd0, 32'd0);
      #1;
      chk("t5_waw_stall", {31'b0, ready_o}, 32'd0);
      rd_wen_i = 1'b0;
      #1;
      chk("t5_no_wen_ok", {31'b0, ready_o}, 32'd1);
      valid_i = 1'b0;

      // 6. Set on x6 beats a same-cycle writeback clear; wb to idle reg leaves busy alone
      present(32'h00006666, 5'd0, 5'd0, 5'd6, 1'b1, 32'd0, 32'd0);
      tick();
      valid_i = 1'b0;
      chk("t6_busy6_first", {31'b0, dut.busy[6]}, 32'd1);
      present(32'h00006767, 5'd0, 5'd0, 5'd6, 1'b1, 32'd0, 32'd0);
      wb(1'b1, 5'd6, 32'h0000_0066);
      #1;
      chk("t6_ready", {31'b0, ready_o}, 32'd1);
      tick();
      valid_i = 1'b0;
      chk("t6_busy6_after", {31'b0, dut.busy[6]}, 32'd1);
      wb(1'b1, 5'd9, 32'h0000_0099);
      tick();
      wb(1'b0, '0, '0);
      chk("t6_busy9_idle", {31'b0, dut.busy[9]}, 32'd0);
      chk("t6_busy_vec", dut.busy, 32'h0000_01D0);

      // Reset while a RAW stall is pending on x7
      present(32'h00007777, 5'd7, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("rs_stall", {31'b0, ready_o}, 32'd0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0; valid_i = 1'b0;
      chk("rs_busy", dut.busy, 32'd0);
      chk("rs_valid", {31'b0, valid_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
